// File: rtl/fifo_pkg.sv
// Shared derivations for fifo_watermark: capacity, pointer width and threshold legality.
package fifo_pkg;

    function automatic int depth_of(input int log_depth);
        return 32'sd1 << log_depth;
    endfunction

    // One extra pointer bit so the pointers wrap modulo twice the capacity.
    function automatic int ptr_w(input int log_depth);
        return log_depth + 32'sd1;
    endfunction

    function automatic bit thresh_ok(input int ae_thresh, input int af_thresh, input int depth);
        return (ae_thresh >= 32'sd0) && (ae_thresh < af_thresh) && (af_thresh <= depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write port, combinational read port, no reset.
module fifo_ram #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [2**AW];

    // Write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_watermark.sv
// Single-clock FIFO with occupancy, almost-full/empty watermarks and optional show-ahead.
// Sticky overflow/underflow flags are built only when FIFO_WATERMARK_ERR_EN is defined.
module fifo_watermark
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LOG_DEPTH = 4,
    parameter int AF_THRESH = (2 ** LOG_DEPTH) - 4,
    parameter int AE_THRESH = 2,
    parameter int SHOWAHEAD = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wrreq,
    input  logic [WIDTH-1:0]     data,
    input  logic                 rdreq,
    output logic [WIDTH-1:0]     q,
    output logic                 full,
    output logic                 empty,
    output logic [LOG_DEPTH:0]   usedw,
    output logic                 almost_full,
    output logic                 almost_empty,
    input  logic                 err_clr,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = depth_of(LOG_DEPTH);
    localparam int PW    = ptr_w(LOG_DEPTH);
    localparam logic [PW-1:0] DEPTH_V = PW'(DEPTH);
    localparam logic [PW-1:0] AF_V    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_V    = PW'(AE_THRESH);

    generate
        if (!thresh_ok(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_params
            $error("fifo_watermark: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_usedw;
    logic             r_full;
    logic             r_empty;
    logic             r_af;
    logic             r_ae;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [PW-1:0]    w_usedw_nxt;
    logic [WIDTH-1:0] w_rd_data;

    // Acceptance uses the registered flags, so full/empty are sampled before the edge.
    always_comb begin
        w_wr_acc    = wrreq & ~r_full;
        w_rd_acc    = rdreq & ~r_empty;
        w_usedw_nxt = r_usedw;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_usedw_nxt = r_usedw + PW'(1);
            2'b01:   w_usedw_nxt = r_usedw - PW'(1);
            default: w_usedw_nxt = r_usedw;
        endcase
    end

    // Pointers, occupancy and flags; flags are decoded from the next count so all are registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_af     <= (AF_V == '0);
            r_ae     <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_acc ? r_wr_ptr + PW'(1) : r_wr_ptr;
            r_rd_ptr <= w_rd_acc ? r_rd_ptr + PW'(1) : r_rd_ptr;
            r_usedw  <= w_usedw_nxt;
            r_full   <= (w_usedw_nxt == DEPTH_V);
            r_empty  <= (w_usedw_nxt == '0);
            r_af     <= (w_usedw_nxt >= AF_V);
            r_ae     <= (w_usedw_nxt <= AE_V);
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (LOG_DEPTH)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[LOG_DEPTH-1:0]),
        .i_wdata (data),
        .i_raddr (r_rd_ptr[LOG_DEPTH-1:0]),
        .o_rdata (w_rd_data)
    );

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            // Head word is presented directly; zero while empty keeps reset value defined.
            assign q = r_empty ? '0 : w_rd_data;
        end else begin : g_registered
            logic [WIDTH-1:0] r_q;

            // Registered read data, loaded only on an accepted read.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_q <= '0;
                end else if (w_rd_acc) begin
                    r_q <= w_rd_data;
                end else begin
                    r_q <= r_q;
                end
            end

            assign q = r_q;
        end
    endgenerate

`ifdef FIFO_WATERMARK_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wrreq & r_full)  | (r_overflow  & ~err_clr);
            r_underflow <= (rdreq & r_empty) | (r_underflow & ~err_clr);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    assign usedw        = r_usedw;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_af;
    assign almost_empty = r_ae;

endmodule

// File: tb/tb_fifo_watermark.sv
// Directed self-checking bench: registered-read and show-ahead instances share one stimulus.
module tb_fifo_watermark;

`ifdef FIFO_WATERMARK_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        wrreq;
    logic [15:0] data;
    logic        rdreq;
    logic        err_clr;

    logic [15:0] q_r, q_s;
    logic        full_r, full_s, empty_r, empty_s;
    logic [4:0]  usedw_r, usedw_s;
    logic        af_r, af_s, ae_r, ae_s;
    logic        ovf_r, ovf_s, udf_r, udf_s;

    int checks;
    int failures;

    fifo_watermark #(.WIDTH(16), .LOG_DEPTH(4), .AF_THRESH(12), .AE_THRESH(2), .SHOWAHEAD(0)) u_reg (
        .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_r), .full(full_r), .empty(empty_r), .usedw(usedw_r),
        .almost_full(af_r), .almost_empty(ae_r), .err_clr(err_clr),
        .overflow(ovf_r), .underflow(udf_r)
    );

    fifo_watermark #(.WIDTH(16), .LOG_DEPTH(4), .AF_THRESH(12), .AE_THRESH(2), .SHOWAHEAD(1)) u_sa (
        .clock(clock), .reset_n(reset_n), .wrreq(wrreq), .data(data), .rdreq(rdreq),
        .q(q_s), .full(full_s), .empty(empty_s), .usedw(usedw_s),
        .almost_full(af_s), .almost_empty(ae_s), .err_clr(err_clr),
        .overflow(ovf_s), .underflow(udf_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wrreq = 1'b0; rdreq = 1'b0; err_clr = 1'b0; data = 16'h0000;
        #12;
        checks++; if (empty_r !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty_r); end
        checks++; if (ae_r !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%0b exp=1", ae_r); end
        checks++; if (usedw_r !== 5'd0) begin failures++; $display("FAIL reset_usedw got=%0d exp=0", usedw_r); end
        checks++; if (q_r !== 16'h0000) begin failures++; $display("FAIL reset_q got=%0h exp=0", q_r); end
        checks++; if ({full_r, af_r, ovf_r, udf_r} !== 4'b0000)
            begin failures++; $display("FAIL reset_flags got=%b exp=0000", {full_r, af_r, ovf_r, udf_r}); end
        checks++; if (empty_s !== 1'b1 || q_s !== 16'h0000)
            begin failures++; $display("FAIL reset_sa got empty=%0b q=%0h exp empty=1 q=0", empty_s, q_s); end
        @(negedge clock);
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            wrreq = 1'b1; data = 16'(i);
            step();
            checks++; if (usedw_r !== 5'(i + 1)) begin failures++; $display("FAIL fill_usedw[%0d] got=%0d exp=%0d", i, usedw_r, i + 1); end
            checks++; if (ae_r !== ((i + 1) <= 2)) begin failures++; $display("FAIL fill_almost_empty[%0d] got=%0b exp=%0b", i, ae_r, ((i + 1) <= 2)); end
            checks++; if (af_r !== ((i + 1) >= 12)) begin failures++; $display("FAIL fill_almost_full[%0d] got=%0b exp=%0b", i, af_r, ((i + 1) >= 12)); end
            checks++; if (full_r !== (i == 15)) begin failures++; $display("FAIL fill_full[%0d] got=%0b exp=%0b", i, full_r, (i == 15)); end
            checks++; if (empty_r !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%0b exp=0", i, empty_r); end
        end
        data = 16'hDEAD;
        step();
        wrreq = 1'b0;
        checks++; if (usedw_r !== 5'd16) begin failures++; $display("FAIL overflow_usedw got=%0d exp=16", usedw_r); end
        checks++; if (ovf_r !== ERR_EN) begin failures++; $display("FAIL overflow_flag got=%0b exp=%0b", ovf_r, ERR_EN); end
        checks++; if (q_s !== 16'h0000) begin failures++; $display("FAIL sa_head_full got=%0h exp=0", q_s); end
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < 16; i++) begin
            rdreq = 1'b1;
            step();
            checks++; if (q_r !== 16'(i)) begin failures++; $display("FAIL drain_q[%0d] got=%0h exp=%0h", i, q_r, i); end
            checks++; if (usedw_r !== 5'(15 - i)) begin failures++; $display("FAIL drain_usedw[%0d] got=%0d exp=%0d", i, usedw_r, 15 - i); end
            checks++; if (full_r !== 1'b0) begin failures++; $display("FAIL drain_full[%0d] got=%0b exp=0", i, full_r); end
        end
        rdreq = 1'b0;
        checks++; if (empty_r !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty_r); end
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
        checks++; if (udf_r !== ERR_EN) begin failures++; $display("FAIL underflow_flag got=%0b exp=%0b", udf_r, ERR_EN); end
        checks++; if (q_r !== 16'h000F) begin failures++; $display("FAIL underflow_q_hold got=%0h exp=f", q_r); end
        checks++; if (usedw_r !== 5'd0) begin failures++; $display("FAIL underflow_usedw got=%0d exp=0", usedw_r); end
    endtask

    task automatic test_err_clr();
        // Read on empty together with clear: underflow set wins, overflow clears.
        rdreq = 1'b1; err_clr = 1'b1;
        step();
        rdreq = 1'b0;
        checks++; if (udf_r !== ERR_EN) begin failures++; $display("FAIL clr_set_wins got=%0b exp=%0b", udf_r, ERR_EN); end
        checks++; if (ovf_r !== 1'b0) begin failures++; $display("FAIL clr_overflow got=%0b exp=0", ovf_r); end
        step();
        err_clr = 1'b0;
        checks++; if ({ovf_r, udf_r} !== 2'b00) begin failures++; $display("FAIL clr_both got=%b exp=00", {ovf_r, udf_r}); end
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 8; i++) begin
            wrreq = 1'b1; data = 16'(100 + i);
            step();
        end
        checks++; if (usedw_r !== 5'd8) begin failures++; $display("FAIL conc_preload got=%0d exp=8", usedw_r); end
        for (int k = 0; k < 20; k++) begin
            wrreq = 1'b1; rdreq = 1'b1; data = 16'(108 + k);
            step();
            checks++; if (usedw_r !== 5'd8) begin failures++; $display("FAIL conc_usedw[%0d] got=%0d exp=8", k, usedw_r); end
            checks++; if (q_r !== 16'(100 + k)) begin failures++; $display("FAIL conc_q[%0d] got=%0d exp=%0d", k, q_r, 100 + k); end
        end
        wrreq = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rdreq = 1'b1;
            step();
            checks++; if (q_r !== 16'(120 + k)) begin failures++; $display("FAIL conc_drain_q[%0d] got=%0d exp=%0d", k, q_r, 120 + k); end
        end
        rdreq = 1'b0;
        checks++; if (empty_r !== 1'b1) begin failures++; $display("FAIL conc_empty got=%0b exp=1", empty_r); end
    endtask

    task automatic test_showahead();
        wrreq = 1'b1; data = 16'hA5A5;
        step();
        wrreq = 1'b0;
        checks++; if (q_s !== 16'hA5A5) begin failures++; $display("FAIL sa_q got=%0h exp=a5a5", q_s); end
        checks++; if (empty_s !== 1'b0) begin failures++; $display("FAIL sa_not_empty got=%0b exp=0", empty_s); end
        step();
        checks++; if (q_s !== 16'hA5A5) begin failures++; $display("FAIL sa_q_hold got=%0h exp=a5a5", q_s); end
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
        checks++; if (empty_s !== 1'b1) begin failures++; $display("FAIL sa_ack_empty got=%0b exp=1", empty_s); end
        checks++; if (q_r !== 16'hA5A5) begin failures++; $display("FAIL reg_q_after_ack got=%0h exp=a5a5", q_r); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1; data = 16'(200 + i);
            step();
        end
        wrreq = 1'b0;
        checks++; if (usedw_r !== 5'd5) begin failures++; $display("FAIL arst_pre_usedw got=%0d exp=5", usedw_r); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (usedw_r !== 5'd0) begin failures++; $display("FAIL arst_usedw got=%0d exp=0", usedw_r); end
        checks++; if (empty_r !== 1'b1) begin failures++; $display("FAIL arst_empty got=%0b exp=1", empty_r); end
        checks++; if (q_r !== 16'h0000) begin failures++; $display("FAIL arst_q got=%0h exp=0", q_r); end
        @(negedge clock);
        reset_n = 1'b1;
        step();
        checks++; if (empty_r !== 1'b1 || usedw_r !== 5'd0)
            begin failures++; $display("FAIL arst_after got empty=%0b usedw=%0d exp 1/0", empty_r, usedw_r); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_err_clr();
        test_concurrent();
        test_showahead();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
